rpn_stack_core: RTL

Parametrised RPN execution core: a hardware operand stack of configurable width and depth, plus a command FSM that pushes operands and applies 3-bit operations to the top two entries. It sits between the key/switch input sequencer, which supplies single-cycle strobes, and the base converter / 7-segment display path, which consumes `top_o`. It generalises the fixed 8-bit, A/B-only calculator to an N-deep stack. It adds a multi-cycle multiply, sticky-free error reporting, and a busy handshake.

---
 rtl/rpn_stack_core_pkg.sv | 34 +++
 rtl/rpn_stack_core_if.sv | 31 +++
 rtl/rpn_stack_core_mul.sv | 47 ++++
 rtl/rpn_stack_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rpn_stack_core_pkg.sv
// Shared RPN core types: opcodes, command FSM states and the ALU flag bundle.
// Imported by the stack core as well as the operation decoder and display blocks.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MUL = 3'b110,
        OP_CLR = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_WB
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } flags_t;

    // Ops that consume the top two entries and leave one result.
    function automatic logic is_binary(opcode_e op);
        return !(op == OP_NOT || op == OP_CLR);
    endfunction

endpackage

// File: rtl/rpn_stack_core_if.sv
// Command/status bundle between the input sequencer and the RPN stack core.
interface rpn_stack_core_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             push_i;
    logic             op_i;
    logic [WIDTH-1:0] data_i;
    logic [2:0]       opcode_i;
    logic [WIDTH-1:0] top_o;
    logic [DW-1:0]    depth_o;
    logic             busy_o;
    logic             empty_o;
    logic             full_o;
    logic             zero_o;
    logic             carry_o;
    logic             ovf_o;
    logic             err_o;

    modport master (
        output push_i, op_i, data_i, opcode_i,
        input  top_o, depth_o, busy_o, empty_o, full_o, zero_o, carry_o, ovf_o, err_o
    );

    modport slave (
        input  push_i, op_i, data_i, opcode_i,
        output top_o, depth_o, busy_o, empty_o, full_o, zero_o, carry_o, ovf_o, err_o
    );
endinterface

// File: rtl/rpn_stack_core_mul.sv
// Shift-add multiplier: bit 0 is folded in on the start edge, so the full
// product is registered WIDTH-1 cycles after start and done rises with it.
module rpn_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CW'(1);
            run     <= 1'b1;
            done    <= 1'b0;
        end else if (run) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/rpn_stack_core.sv
// RPN execution core: register-array operand stack plus a command FSM that
// pushes operands and applies ALU/multiply ops to the top two entries.
module rpn_stack_core
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        rst,
    rpn_stack_core_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [DW-1:0]    sp;
    state_e           state_q, state_d;
    opcode_e          opc_q, opc_in;
    flags_t           flags_q, alu_flags;
    logic             err_q;

    logic accept, do_err, do_push, do_clr, commit, mul_start, mul_done;
    logic is_empty, is_full;
    logic [AW-1:0]      ia, ib;
    logic [WIDTH-1:0]   opa, opb, alu_res;
    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] mul_prod;

    assign opc_in   = opcode_e'(bus.opcode_i);
    assign is_empty = (sp == '0);
    assign is_full  = (sp == DW'(DEPTH));
    assign ib       = AW'(sp - DW'(1));
    assign ia       = AW'(sp - DW'(2));
    assign opa      = stack[ia];
    assign opb      = stack[ib];

    rpn_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        sum       = {1'b0, opa} + {1'b0, opb};
        dif       = {1'b0, opa} - {1'b0, opb};
        alu_res   = '0;
        alu_flags = '0;
        case (opc_q)
            OP_ADD: begin
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
                alu_flags.ovf   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res         = dif[WIDTH-1:0];
                alu_flags.carry = dif[WIDTH];
                alu_flags.ovf   = (opa[WIDTH-1] != opb[WIDTH-1]) && (dif[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_NOT: alu_res = ~opb;
            OP_MUL: begin
                alu_res       = mul_prod[WIDTH-1:0];
                alu_flags.ovf = |mul_prod[2*WIDTH-1:WIDTH];
            end
            default: alu_res = '0;
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    // The result lands on the edge into WB, so WB already looks idle and
    // takes the next strobe in the first cycle busy is low.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        do_err    = 1'b0;
        do_push   = 1'b0;
        do_clr    = 1'b0;
        commit    = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_WB: begin
                state_d = ST_IDLE;
                if (bus.op_i) begin
                    accept = 1'b1;
                    if (opc_in == OP_CLR)
                        do_clr = 1'b1;
                    else if ((opc_in == OP_NOT && is_empty) || (is_binary(opc_in) && sp < DW'(2)))
                        do_err = 1'b1;
                    else
                        state_d = ST_EXEC;
                end else if (bus.push_i) begin
                    accept = 1'b1;
                    if (is_full) do_err  = 1'b1;
                    else         do_push = 1'b1;
                end
            end
            ST_EXEC: begin
                if (opc_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_WB;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    commit  = 1'b1;
                    state_d = ST_WB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sp      <= '0;
            opc_q   <= OP_ADD;
            flags_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q <= do_err;
                opc_q <= opc_in;
            end
            if (do_push) begin
                stack[AW'(sp)] <= bus.data_i;
                sp             <= sp + DW'(1);
            end
            if (do_clr) begin
                sp      <= '0;
                flags_q <= '0;
            end
            if (commit) begin
                flags_q <= alu_flags;
                if (opc_q == OP_NOT) begin
                    stack[ib] <= alu_res;
                end else begin
                    stack[ia] <= alu_res;
                    sp        <= sp - DW'(1);
                end
            end
        end
    end

    assign bus.top_o   = is_empty ? '0 : opb;
    assign bus.depth_o = sp;
    assign bus.busy_o  = (state_q == ST_EXEC) || (state_q == ST_MUL);
    assign bus.empty_o = is_empty;
    assign bus.full_o  = is_full;
    assign bus.zero_o  = flags_q.zero;
    assign bus.carry_o = flags_q.carry;
    assign bus.ovf_o   = flags_q.ovf;
    assign bus.err_o   = err_q;
endmodule
